instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction ROM: owns the fetch PC, drives the ROM byte address and captures the combinational ROM word.
- Buffers fetched {pc, instr} pairs in a small prefetch FIFO.
- Presents them to decode through a valid/ready handshake.
- Accepts redirects (branch/jump) that flush the buffer and restart fetch at a new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_addr  output  32  byte address to ROM; equals fetch_pc combinationally.
- rom_data  input  32  instruction word returned combinationally by ROM for rom_addr.
- redirect_valid  input  1  one-cycle request to restart fetch.
- redirect_pc  input  32  target byte address; bits [1:0] ignored.
- out_valid  output  1  FIFO head holds a valid entry.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  instruction at FIFO head.
- out_pc  output  32  PC of out_instr.
- out_pc_plus4  output  32  out_pc + 4, modulo 2^32.

Behaviour:
- Reset (sampled at rising edge while reset=1):
  - fetch_pc <= RESET_PC with [1:0] forced to 0.
  - FIFO count <= 0; out_valid=0.
  - out_instr, out_pc, out_pc_plus4 = 0 while empty.
  - Reset mid-operation discards all entries and any same-cycle redirect.
- Pop: out_valid & out_ready; the head is removed at the clock edge.
- Push: occurs when (count < FIFO_DEPTH) | pop, and no redirect.
  - Writes {fetch_pc, rom_data} at the tail.
  - fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0.
- Full with no pop: no push; fetch_pc and rom_addr hold; no entry lost or duplicated.
- Simultaneous push and pop: count unchanged, giving throughput of 1 instruction/cycle when full.
- Redirect (highest priority below reset):
  - FIFO flushed (count <= 0).
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - A pop in the same cycle is still reported to decode but the entry is discarded by the flush.
- Latency:
  - Out of reset, first push at the first edge with reset=0; out_valid=1 the following cycle with out_pc=RESET_PC.
  - After redirect: out_valid=0 for exactly one cycle, then the target entry is at the head.
- Output regs: out_* come from FIFO storage, with no combinational path from rom_data. out_pc_plus4 may be computed from the stored pc.
- FIFO pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
- FSM states, derived from count:
  - EMPTY (count=0), PARTIAL, FULL (count=FIFO_DEPTH).
  - Transitions: push only +1, pop only -1, both = hold, redirect/reset -> EMPTY.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two outputs:
  - fetch_count [31:0]: increments on every push.
  - stall_count [31:0]: increments on every cycle where FIFO is full and there is no pop and no redirect.
- Both reset to 0 and wrap at 2^32; a redirect does not clear them.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_entry_t (struct packed {logic [31:0] pc; logic [31:0] instr;}).
  - localparam DEFAULT_RESET_PC = 32'h0.
  - localparam INSTR_NOP = 32'h0000_0013.
  - localparam PC_STEP = 4.
- One sub-module, fetch_fifo:
  - Parameterised by depth.
  - Signals: push/pop/flush, fetch_entry_t data, full/empty/count.
  - Instantiated once; the PC register and control stay in the top.

Test Plan:
- Reset, out_ready=1, ROM rom[i]=32'h1000_0000+i → out_valid rises the 2nd cycle after reset release.
  - out_pc sequence 0x0, 0x4, 0x8; out_instr 0x1000_0000, 0x1000_0001, ...; out_pc_plus4 = out_pc+4.
- out_ready=0 for 5 cycles after the first valid → count saturates at 2, rom_addr holds 0x8, out_pc stays 0x0.
  - On release, entries 0x0, 0x4, 0x8 are delivered consecutively with no gaps or duplicates.
- redirect_valid with redirect_pc=0x40 while FIFO full → next cycle out_valid=0.
  - Following cycle out_pc=0x40, out_instr=rom[16]; no stale 0x4/0x8 entries are emitted.
- redirect_pc=0x43 → fetch resumes at 0x40; redirect asserted in the same cycle as reset → fetch_pc=RESET_PC.
- RESET_PC=32'hFFFF_FFF8 → out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - out_pc_plus4 at 0xFFFF_FFFC equals 0x0.
- With FETCH_PERF_CNT_EN, the scenario-2 stall → stall_count=4, i.e. the cycles full-without-pop after fill.
  - fetch_count equals the total number of pushes, including pushes later flushed by a redirect.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit (package fetch_pkg).
// The fetch unit's optional FETCH_PERF_CNT_EN build uses nothing extra from here.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_PARTIAL = 2'd1,
      ST_FULL    = 2'd2
   } fifo_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Instructions are word aligned; the low two address bits are dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO (module fetch_fifo) holding {pc, instr} pairs between the ROM and decode.
// Occupancy is tracked as an EMPTY/PARTIAL/FULL state alongside the raw count.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wr_data,
   output fetch_entry_t  rd_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t          mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count_nxt;
   fifo_state_t           state;
   fifo_state_t           state_nxt;
   logic                  do_push;
   logic                  do_pop;

   assign do_pop  = pop & (state != ST_EMPTY);
   assign do_push = push & ((state != ST_FULL) | do_pop);

   always_comb begin
      count_nxt = count;
      case ({do_push, do_pop})
         2'b10:   count_nxt = count + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   count_nxt = count - {{(CW-1){1'b0}}, 1'b1};
         default: count_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt = ST_PARTIAL;
      if (count_nxt == {CW{1'b0}}) begin
         state_nxt = ST_EMPTY;
      end else if (count_nxt == CW'(DEPTH)) begin
         state_nxt = ST_FULL;
      end else begin
         state_nxt = ST_PARTIAL;
      end
   end

   // Flush drops every entry by resetting the pointers; storage is left as is.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= {PW{1'b0}};
         rd_ptr <= {PW{1'b0}};
         count  <= {CW{1'b0}};
         state  <= ST_EMPTY;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         count <= count_nxt;
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !reset && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_ptr];
   assign empty   = (state == ST_EMPTY);
   assign full    = (state == ST_FULL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, captures ROM words into a prefetch FIFO
// and hands them to decode. Defining FETCH_PERF_CNT_EN adds fetch/stall counters.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [31:0] out_pc_plus4
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [31:0]   fetch_pc;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  wr_entry;
   fetch_entry_t  head;

   assign pop      = out_valid & out_ready;
   assign push     = ((fifo_count < CW'(FIFO_DEPTH)) | pop) & ~redirect_valid;
   assign wr_entry = '{pc: fetch_pc, instr: rom_data};
   assign rom_addr = fetch_pc;

   // Fetch PC: redirect wins over sequential advance; a blocked push holds it.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc <= align_pc(RESET_PC);
      end else if (redirect_valid) begin
         fetch_pc <= align_pc(redirect_pc);
      end else if (push) begin
         fetch_pc <= fetch_pc + PC_STEP;
      end else begin
         fetch_pc <= fetch_pc;
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wr_data (wr_entry),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Outputs read straight from FIFO storage and are zeroed while nothing is held.
   always_comb begin
      out_valid    = 1'b0;
      out_pc       = 32'h0000_0000;
      out_instr    = 32'h0000_0000;
      out_pc_plus4 = 32'h0000_0000;
      if (!fifo_empty) begin
         out_valid    = 1'b1;
         out_pc       = head.pc;
         out_instr    = head.instr;
         out_pc_plus4 = head.pc + PC_STEP;
      end else begin
         out_valid    = 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // Pushes later discarded by a redirect still count as fetches.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_count <= 32'h0000_0000;
         stall_count <= 32'h0000_0000;
      end else begin
         if (push) begin
            fetch_count <= fetch_count + 32'd1;
         end
         if (fifo_full && !pop && !redirect_valid) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end
`else
   logic unused_full;
   assign unused_full = fifo_full;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: queue-based reference model plus
// directed scenarios; a second instance exercises PC wrap from a high RESET_PC.
module tb_instr_fetch_unit;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RST_PC_A = 32'h0000_0000;
   localparam logic [31:0] RST_PC_B = 32'hFFFF_FFF8;

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_ready;

   logic [31:0] rom_addr, rom_data, out_instr, out_pc, out_pc_plus4;
   logic        out_valid;
   logic [31:0] rom_addr2, rom_data2, out_instr2, out_pc2, out_pc_plus4_2;
   logic        out_valid2;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

   int checks;
   int errors;

   // reference model state
   logic [63:0] mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return 32'h1000_0000 + (a >> 2);
   endfunction

   assign rom_data  = rom_word(rom_addr);
   assign rom_data2 = rom_word(rom_addr2);

   instr_fetch_unit #(.RESET_PC(RST_PC_A), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_pc_plus4   (out_pc_plus4)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count),
      .stall_count    (stall_count)
`endif
   );

   instr_fetch_unit #(.RESET_PC(RST_PC_B), .FIFO_DEPTH(DEPTH)) u_dut_wrap (
      .clk            (clk),
      .reset          (reset),
      .rom_addr       (rom_addr2),
      .rom_data       (rom_data2),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0000_0000),
      .out_valid      (out_valid2),
      .out_ready      (1'b1),
      .out_instr      (out_instr2),
      .out_pc         (out_pc2),
      .out_pc_plus4   (out_pc_plus4_2)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count    (fetch_count2),
      .stall_count    (stall_count2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one clock edge of the behavioural rules to the model.
   task automatic model_edge();
      logic did_pop;
      if (reset) begin
         mq.delete();
         m_pc    = {RST_PC_A[31:2], 2'b00};
         m_fetch = 32'd0;
         m_stall = 32'd0;
      end else if (redirect_valid) begin
         mq.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         did_pop = (mq.size() > 0) && out_ready;
         if (mq.size() == DEPTH && !did_pop) m_stall = m_stall + 32'd1;
         if (did_pop) void'(mq.pop_front());
         if (mq.size() < DEPTH) begin
            mq.push_back({m_pc, rom_word(m_pc)});
            m_pc    = m_pc + 32'd4;
            m_fetch = m_fetch + 32'd1;
         end
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [128:0] exp_vec();
      logic [63:0] h;
      if (mq.size() > 0) begin
         h = mq[0];
         return {1'b1, h[63:32], h[31:0], h[63:32] + 32'd4, m_pc};
      end
      return {1'b0, 96'd0, m_pc};
   endfunction

   function automatic logic [128:0] act_vec();
      return {out_valid, out_pc, out_instr, out_pc_plus4, rom_addr};
   endfunction

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0080; out_ready = 1'b1;
      step();
      step();
      checks++;
      if (act_vec() !== exp_vec()) begin
         errors++; $display("FAIL reset_state: got %h expected %h", act_vec(), exp_vec());
      end
      checks++;
      if (rom_addr !== 32'h0000_0000) begin
         errors++; $display("FAIL reset_beats_redirect: rom_addr got %h expected 00000000", rom_addr);
      end
      redirect_valid = 1'b0;
   endtask

   task automatic test_stream();
      reset = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL stream_%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
            errors++; $display("FAIL stream_pc_%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4));
         end
      end
   endtask

   task automatic test_stall();
      reset = 1'b1; out_ready = 1'b1;
      step();
      reset = 1'b0;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall_%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
      end
      checks++;
      if (rom_addr !== 32'h0000_0008 || out_pc !== 32'h0000_0000) begin
         errors++; $display("FAIL stall_hold: got addr=%h pc=%h expected addr=00000008 pc=00000000", rom_addr, out_pc);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++;
      if (stall_count !== 32'd4 || fetch_count !== 32'd2) begin
         errors++; $display("FAIL stall_perf: got stall=%0d fetch=%0d expected stall=4 fetch=2", stall_count, fetch_count);
      end
`endif
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) begin
            errors++; $display("FAIL drain_%0d: got v=%b pc=%h expected v=1 pc=%h", i, out_valid, out_pc, 32'(i * 4));
         end
         step();
      end
   endtask

   task automatic test_redirect();
      out_ready = 1'b0;
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0040; out_ready = 1'b1;
      step();
      redirect_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || rom_addr !== 32'h0000_0040) begin
         errors++; $display("FAIL redir_bubble: got v=%b addr=%h expected v=0 addr=00000040", out_valid, rom_addr);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0000_0040 || out_instr !== 32'h1000_0010) begin
         errors++; $display("FAIL redir_target: got v=%b pc=%h instr=%h expected v=1 pc=00000040 instr=10000010", out_valid, out_pc, out_instr);
      end
      step();
      checks++;
      if (act_vec() !== exp_vec() || out_pc !== 32'h0000_0044) begin
         errors++; $display("FAIL redir_next: got %h expected %h", act_vec(), exp_vec());
      end
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
      step();
      redirect_valid = 1'b0;
      step();
      checks++;
      if (out_pc !== 32'h0000_0040 || out_valid !== 1'b1) begin
         errors++; $display("FAIL redir_unaligned: got v=%b pc=%h expected v=1 pc=00000040", out_valid, out_pc);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
      reset = 1'b1; out_ready = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (out_valid2 !== 1'b1 || out_pc2 !== exp_pc[i] || out_pc_plus4_2 !== exp_pc[i] + 32'd4
             || out_instr2 !== rom_word(exp_pc[i])) begin
            errors++;
            $display("FAIL wrap_%0d: got v=%b pc=%h p4=%h instr=%h expected pc=%h p4=%h instr=%h", i, out_valid2,
                     out_pc2, out_pc_plus4_2, out_instr2, exp_pc[i], exp_pc[i] + 32'd4, rom_word(exp_pc[i]));
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         redirect_valid = ($urandom_range(0, 9) == 0);
         redirect_pc    = $urandom;
         reset          = ($urandom_range(0, 49) == 0);
         step();
         checks++;
         if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL random_%0d: got %h expected %h", i, act_vec(), exp_vec());
         end
`ifdef FETCH_PERF_CNT_EN
         checks++;
         if (fetch_count !== m_fetch || stall_count !== m_stall) begin
            errors++; $display("FAIL random_perf_%0d: got fetch=%0d stall=%0d expected fetch=%0d stall=%0d",
                               i, fetch_count, stall_count, m_fetch, m_stall);
         end
`endif
      end
      reset = 1'b0; redirect_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      m_pc = 32'd0; m_fetch = 32'd0; m_stall = 32'd0;
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
